if_fetch_pc: RTL

- IF-stage front end that owns the program counter and computes next-PC. Presents the fetch address to instruction memory.
- Detects fetch address exceptions and tracks branch-delay-slot status.
- Produces Instr / PC+4 / PC+8 / ExcCode for the IF/D pipeline register, which sits directly downstream.
- Applies redirects decided in D (branch/jump/jr), exception entry and eret from the CP0/M side, and stall hold from the hazard unit.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/if_fetch_pc_if.sv | 41 ++++
 rtl/if_addr_check.sv | 22 ++
 rtl/if_fetch_pc.sv | 91 +++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception codes, next-PC select encodings and
// default memory-map constants used by the fetch front end and its helpers.
package cpu_defs;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    localparam logic [31:0] DEF_PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO      = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI      = 32'h0000_6FFC;

endpackage

// File: rtl/if_fetch_pc_if.sv
// Bundle between the fetch front end and its neighbours: redirect and
// exception controls in, instruction-memory address and IF/D payload out.
interface if_fetch_pc_if;

    logic        en;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        d_is_ctrl;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] im_rdata;

    logic [31:0] instr_addr;
    logic [31:0] Instr_out;
    logic [31:0] PC_plus_4;
    logic [31:0] PC_plus_8;
    logic [6:2]  ExcCode_out;
    logic        bd_out;
    logic [31:0] pc;

    // Surrounding pipeline (D stage, CP0, hazard unit, instruction memory)
    modport master (
        output en, npc_sel, br_taken, br_target, j_target, jr_target,
        output d_is_ctrl, exc_req, eret_req, epc, im_rdata,
        input  instr_addr, Instr_out, PC_plus_4, PC_plus_8, ExcCode_out,
        input  bd_out, pc
    );

    // Fetch front end
    modport slave (
        input  en, npc_sel, br_taken, br_target, j_target, jr_target,
        input  d_is_ctrl, exc_req, eret_req, epc, im_rdata,
        output instr_addr, Instr_out, PC_plus_4, PC_plus_8, ExcCode_out,
        output bd_out, pc
    );

endinterface

// File: rtl/if_addr_check.sv
// Combinational word-address legality check: flags misaligned addresses and
// addresses outside the inclusive window [LO, HI]. Shared by fetch and data
// side address-error detection.
module if_addr_check
    import cpu_defs::*;
#(
    parameter logic [31:0] LO = DEF_IM_LO,
    parameter logic [31:0] HI = DEF_IM_HI
) (
    input  logic [31:0] addr,
    output logic        addr_exc
);

    // Misalignment or out-of-window access raises an address error
    always_comb begin
        addr_exc = 1'b0;
        if (addr[1:0] != 2'b00) addr_exc = 1'b1;
        if (addr < LO)          addr_exc = 1'b1;
        if (addr > HI)          addr_exc = 1'b1;
    end

endmodule

// File: rtl/if_fetch_pc.sv
// IF-stage front end: owns the PC, selects the next fetch address from
// redirects/exceptions/stalls, tracks delay-slot status and flags bad
// fetch addresses so a nop with AdEL enters IF/D instead.
module if_fetch_pc
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_RESET   = DEF_PC_RESET,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] IM_LO      = DEF_IM_LO,
    parameter logic [31:0] IM_HI      = DEF_IM_HI
) (
    input  logic         clk,
    input  logic         reset,
    if_fetch_pc_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        bd_q;
    logic        bd_d;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        fetch_exc;

    // Sequential successors; 32-bit wrap past 0xFFFF_FFFC is intentional
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_plus8 = pc_q + 32'd8;
    end

    // Next-PC priority: exception, eret, stall hold, then D-stage redirect
    always_comb begin
        pc_d = pc_plus4;
        if (bus.exc_req) begin
            pc_d = EXC_VECTOR;
        end else if (bus.eret_req) begin
            pc_d = bus.epc;
        end else if (!bus.en) begin
            // Redirect is dropped; D re-presents it once the stall clears
            pc_d = pc_q;
        end else begin
            case (bus.npc_sel)
                NPC_BR:  pc_d = bus.br_taken ? bus.br_target : pc_plus4;
                NPC_J:   pc_d = bus.j_target;
                NPC_JR:  pc_d = bus.jr_target;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    // Delay-slot flag: cleared on exception/eret, sampled from D when advancing
    always_comb begin
        bd_d = bd_q;
        if (bus.exc_req || bus.eret_req) begin
            bd_d = 1'b0;
        end else if (bus.en) begin
            bd_d = bus.d_is_ctrl;
        end
    end

    // PC and delay-slot state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= PC_RESET;
            bd_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            bd_q <= bd_d;
        end
    end

    if_addr_check #(
        .LO (IM_LO),
        .HI (IM_HI)
    ) u_addr_check (
        .addr     (pc_q),
        .addr_exc (fetch_exc)
    );

    // IF/D payload; a bad fetch turns into a nop tagged with AdEL
    always_comb begin
        bus.instr_addr  = pc_q;
        bus.pc          = pc_q;
        bus.PC_plus_4   = pc_plus4;
        bus.PC_plus_8   = pc_plus8;
        bus.bd_out      = bd_q;
        bus.Instr_out   = fetch_exc ? 32'd0 : bus.im_rdata;
        bus.ExcCode_out = fetch_exc ? EXC_ADEL : EXC_NONE;
    end

endmodule
